pe_result_writer: RTL and testbench

- Downstream writeback stage of the SIMD PE array.
- Captures the stage-1 lane vectors (STORE_TEMP_S1) and stage-2 scalar sums (STORE_TEMP_S2) produced by the PE datapath and packs them into PE_ELEMENTS-wide result words.
- On store_result (STORE_RESULT) or at program stop, writes each packed word to the result RAM at an auto-incrementing address.
- Runs a small IDLE/RUN/DRAIN/DONE control FSM that reports program completion.

---
 rtl/simd_pkg.sv | 29 ++
 rtl/pe_lane_packer.sv | 80 ++++++++
 rtl/pe_result_writer.sv | 135 +++++++++++++
 tb/tb_pe_result_writer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared SIMD PE array types: opcodes, writeback FSM states, lane vectors.
// Imported by the writeback stage and its lane packer.
package simd_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int PE_ELEMENTS_DEF = 4;

  typedef enum logic [3:0] {
    NOOP,
    ADD,
    SUB,
    MUL,
    DOTP,
    STORE_TEMP_S1,
    STORE_TEMP_S2,
    STORE_RESULT,
    STOP
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } writer_state_t;

  typedef logic [PE_ELEMENTS_DEF-1:0][DATA_WIDTH_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/pe_lane_packer.sv
// Result packing buffer: lane data, lane mask and next-free-lane pointer.
// A commit empties the buffer before same-cycle stage data is applied.
module pe_lane_packer
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PE_ELEMENTS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              run,
  input  logic                              commit,
  input  logic                              stage1_valid,
  input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] stage1_data,
  input  logic                              stage2_valid,
  input  logic [DATA_WIDTH-1:0]             stage2_data,
  output logic [PE_ELEMENTS*DATA_WIDTH-1:0] buffer,
  output logic [PE_ELEMENTS-1:0]            mask,
  output logic                              overflow,
  output logic                              conflict
);

  localparam int PW = $clog2(PE_ELEMENTS + 1);

  logic [PE_ELEMENTS*DATA_WIDTH-1:0] buf_q, buf_d, base_buf;
  logic [PE_ELEMENTS-1:0]            mask_q, mask_d, base_mask;
  logic [PW-1:0]                     ptr_q, ptr_d, base_ptr;

  always_comb begin
    base_buf  = commit ? '0 : buf_q;
    base_mask = commit ? '0 : mask_q;
    base_ptr  = commit ? '0 : ptr_q;
    buf_d     = base_buf;
    mask_d    = base_mask;
    ptr_d     = base_ptr;
    overflow  = 1'b0;
    conflict  = 1'b0;
    if (clear) begin
      buf_d  = '0;
      mask_d = '0;
      ptr_d  = '0;
    end else if (run) begin
      conflict = stage1_valid & stage2_valid;
      if (stage1_valid) begin
        buf_d  = stage1_data;
        mask_d = '1;
        ptr_d  = PW'(PE_ELEMENTS);
      end else if (stage2_valid) begin
        if (base_ptr < PW'(PE_ELEMENTS)) begin
          for (int i = 0; i < PE_ELEMENTS; i++) begin
            if (base_ptr == PW'(i)) begin
              buf_d[i*DATA_WIDTH +: DATA_WIDTH] = stage2_data;
              mask_d[i] = 1'b1;
            end
          end
          ptr_d = base_ptr + 1'b1;
        end else begin
          overflow = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
    end else begin
      buf_q  <= buf_d;
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
    end
  end

  assign buffer = buf_q;
  assign mask   = mask_q;

endmodule

// File: rtl/pe_result_writer.sv
// Writeback stage of the SIMD PE array: commits packed result words to
// the result RAM and reports program completion.
module pe_result_writer
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int PE_ELEMENTS     = 4,
  parameter int DRAM_DEPTH      = 256,
  parameter int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stage1_valid,
  input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] stage1_data,
  input  logic                              stage2_valid,
  input  logic [DATA_WIDTH-1:0]             stage2_data,
  input  logic                              store_result,
  input  logic                              stop_in,
  output logic [DRAM_ADDR_WIDTH-1:0]        ram_result_write_addr,
  output logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_result_write_data,
  output logic                              ram_result_wr_en,
  output logic [PE_ELEMENTS-1:0]            ram_result_wr_mask,
  output logic [DRAM_ADDR_WIDTH:0]          words_written,
  output logic                              done,
  output logic                              err_overflow,
  output logic                              err_conflict,
  output logic                              err_wrap
);

  localparam int AW = DRAM_ADDR_WIDTH;

  writer_state_t state_q, state_d;

  logic [PE_ELEMENTS*DATA_WIDTH-1:0] pk_buf, pk_data;
  logic [PE_ELEMENTS-1:0]            pk_mask;
  logic                              pk_overflow, pk_conflict;
  logic                              run, commit;
  logic [AW-1:0]                     wr_ptr;
  logic                              ptr_last;

  pe_lane_packer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PE_ELEMENTS (PE_ELEMENTS)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .run          (run),
    .commit       (commit),
    .stage1_valid (stage1_valid),
    .stage1_data  (stage1_data),
    .stage2_valid (stage2_valid),
    .stage2_data  (stage2_data),
    .buffer       (pk_buf),
    .mask         (pk_mask),
    .overflow     (pk_overflow),
    .conflict     (pk_conflict)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (start) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN holds until a same-cycle stop leftover has been flushed too
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (stop_in) state_d = DRAIN;
      DRAIN:   if (pk_mask == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    commit = 1'b0;
    if (!start) begin
      unique case (state_q)
        RUN: begin
          run    = 1'b1;
          commit = (store_result | stop_in) & (pk_mask != '0);
        end
        DRAIN:   commit = (pk_mask != '0);
        default: commit = 1'b0;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < PE_ELEMENTS; i++) begin
      pk_data[i*DATA_WIDTH +: DATA_WIDTH] =
        pk_buf[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{pk_mask[i]}};
    end
  end

  assign ptr_last = (wr_ptr == AW'(DRAM_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst || start) begin
      ram_result_write_addr <= '0;
      ram_result_write_data <= '0;
      ram_result_wr_en      <= 1'b0;
      ram_result_wr_mask    <= '0;
      wr_ptr                <= '0;
      words_written         <= '0;
      err_overflow          <= 1'b0;
      err_conflict          <= 1'b0;
      err_wrap              <= 1'b0;
    end else begin
      ram_result_wr_en <= commit;
      if (commit) begin
        ram_result_write_addr <= wr_ptr;
        ram_result_write_data <= pk_data;
        ram_result_wr_mask    <= pk_mask;
        wr_ptr                <= ptr_last ? '0 : wr_ptr + 1'b1;
        if (ptr_last) err_wrap <= 1'b1;
        if (words_written != '1) words_written <= words_written + 1'b1;
      end
      if (pk_overflow) err_overflow <= 1'b1;
      if (pk_conflict) err_conflict <= 1'b1;
    end
  end

  assign done = (state_q == DONE);

endmodule

// File: tb/tb_pe_result_writer.sv
// Directed bench for pe_result_writer with a 4-deep result RAM so that
// pointer wrap is reachable.
module tb_pe_result_writer;

  localparam int DW = 32;
  localparam int PE = 4;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst, start, stage1_valid, stage2_valid;
  logic              store_result, stop_in;
  logic [PE*DW-1:0]  stage1_data;
  logic [DW-1:0]     stage2_data;
  logic [AW-1:0]     ram_result_write_addr;
  logic [PE*DW-1:0]  ram_result_write_data;
  logic              ram_result_wr_en;
  logic [PE-1:0]     ram_result_wr_mask;
  logic [AW:0]       words_written;
  logic              done, err_overflow, err_conflict, err_wrap;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pe_result_writer #(
    .DATA_WIDTH  (DW),
    .PE_ELEMENTS (PE),
    .DRAM_DEPTH  (DEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .stage1_valid          (stage1_valid),
    .stage1_data           (stage1_data),
    .stage2_valid          (stage2_valid),
    .stage2_data           (stage2_data),
    .store_result          (store_result),
    .stop_in               (stop_in),
    .ram_result_write_addr (ram_result_write_addr),
    .ram_result_write_data (ram_result_write_data),
    .ram_result_wr_en      (ram_result_wr_en),
    .ram_result_wr_mask    (ram_result_wr_mask),
    .words_written         (words_written),
    .done                  (done),
    .err_overflow          (err_overflow),
    .err_conflict          (err_conflict),
    .err_wrap              (err_wrap)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start        = 1'b0;
    stage1_valid = 1'b0;
    stage2_valid = 1'b0;
    store_result = 1'b0;
    stop_in      = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  task automatic s1(input logic [PE*DW-1:0] d);
    stage1_valid = 1'b1;
    stage1_data  = d;
    tick();
  endtask

  task automatic s2(input logic [DW-1:0] d);
    stage2_valid = 1'b1;
    stage2_data  = d;
    tick();
  endtask

  task automatic store();
    store_result = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stage1_valid = 1'b0;
    stage2_valid = 1'b0;
    store_result = 1'b0;
    stop_in = 1'b0;
    stage1_data = '0;
    stage2_data = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wr_en", ram_result_wr_en, 0);
    chk("rst_addr", ram_result_write_addr, 0);
    chk("rst_data", ram_result_write_data, 0);
    chk("rst_mask", ram_result_wr_mask, 0);
    chk("rst_ww", words_written, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_overflow, err_conflict, err_wrap}, 0);

    // IDLE ignores data and store
    s1({32'd9, 32'd9, 32'd9, 32'd9});
    store();
    chk("idle_no_write", ram_result_wr_en, 0);

    // stage1 vector then store
    do_start();
    s1({32'd4, 32'd3, 32'd2, 32'd1});
    store();
    chk("s1_wr_en", ram_result_wr_en, 1);
    chk("s1_addr", ram_result_write_addr, 0);
    chk("s1_data", ram_result_write_data, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("s1_mask", ram_result_wr_mask, 4'b1111);
    chk("s1_ww", words_written, 1);
    tick();
    chk("s1_strobe_1cyc", ram_result_wr_en, 0);

    // four stage2 values, fifth overflows
    do_start();
    chk("start_clr_ww", words_written, 0);
    s2(32'd10);
    s2(32'd20);
    s2(32'd30);
    s2(32'd40);
    chk("s2_no_ovf_yet", err_overflow, 0);
    s2(32'd99);
    chk("s2_overflow", err_overflow, 1);
    store();
    chk("s2_wr_en", ram_result_wr_en, 1);
    chk("s2_addr", ram_result_write_addr, 0);
    chk("s2_data", ram_result_write_data,
        {32'd40, 32'd30, 32'd20, 32'd10});
    chk("s2_mask", ram_result_wr_mask, 4'b1111);

    // partial buffer flushed by stop
    do_start();
    chk("start_clr_ovf", err_overflow, 0);
    s2(32'd7);
    s2(32'd9);
    stop_in = 1'b1;
    tick();
    chk("flush_wr_en", ram_result_wr_en, 1);
    chk("flush_mask", ram_result_wr_mask, 4'b0011);
    chk("flush_data", ram_result_write_data, {32'd0, 32'd0, 32'd9, 32'd7});
    chk("flush_addr", ram_result_write_addr, 0);
    chk("flush_not_done", done, 0);
    tick();
    chk("done_set", done, 1);
    chk("done_wr_en", ram_result_wr_en, 0);
    s1({32'd1, 32'd1, 32'd1, 32'd1});
    store();
    chk("done_ignores", ram_result_wr_en, 0);
    chk("done_held", done, 1);

    // store with same-cycle stage1
    do_start();
    chk("start_clr_done", done, 0);
    s2(32'd5);
    store_result = 1'b1;
    s1({32'd8, 32'd8, 32'd8, 32'd8});
    chk("mix_wr_en", ram_result_wr_en, 1);
    chk("mix_data", ram_result_write_data, {32'd0, 32'd0, 32'd0, 32'd5});
    chk("mix_mask", ram_result_wr_mask, 4'b0001);
    store();
    chk("mix2_addr", ram_result_write_addr, 1);
    chk("mix2_data", ram_result_write_data,
        {32'd8, 32'd8, 32'd8, 32'd8});
    chk("mix2_mask", ram_result_wr_mask, 4'b1111);

    // empty store is a no-op, then pointer wrap
    do_start();
    store();
    chk("empty_store", ram_result_wr_en, 0);
    chk("empty_ww", words_written, 0);
    for (int i = 0; i < 5; i++) begin
      s1({4{i[31:0] + 32'd1}});
      store();
      chk("wrap_wr_en", ram_result_wr_en, 1);
      chk("wrap_addr", ram_result_write_addr, i % DEPTH);
      chk("wrap_err", err_wrap, (i >= 3) ? 1 : 0);
    end
    chk("wrap_ww", words_written, 5);

    // conflict, then reset during a write cycle
    do_start();
    stage2_valid = 1'b1;
    stage2_data  = 32'd55;
    s1({32'd4, 32'd3, 32'd2, 32'd1});
    chk("conflict_err", err_conflict, 1);
    store();
    chk("conflict_data", ram_result_write_data,
        {32'd4, 32'd3, 32'd2, 32'd1});
    chk("conflict_wr_en", ram_result_wr_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_wr_en", ram_result_wr_en, 0);
    chk("rst_mid_addr", ram_result_write_addr, 0);
    chk("rst_mid_data", ram_result_write_data, 0);
    chk("rst_mid_ww", words_written, 0);
    chk("rst_mid_errs", {err_overflow, err_conflict, err_wrap}, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
